parking_occupancy_tracker: RTL and testbench
============================================

Name: parking_occupancy_tracker

Overview:
- Multi-lane parking-lot occupancy tracker; generalises the single-gate A/B sensor FSM and counter into N independent gate lanes feeding one shared, capacity-bounded counter.
- Sits between the per-key input synchronisers and the HEX display driver; drives the count plus full/empty/reject status.
- Adds behaviour the single-gate design lacks: lane aborts, reject-on-full, simultaneous multi-lane netting, and saturation.

Parameters:
- LANES, 2, number of gate lanes, 1..8
- CAPACITY, 25, maximum occupancy, 1..255
- CNT_W, $clog2(CAPACITY+1), count width (derived; do not override)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sensor_a  in  LANES  outer sensor per lane, already synchronised, 1 = beam blocked
- sensor_b  in  LANES  inner sensor per lane, already synchronised, 1 = beam blocked
- count  out  CNT_W  current occupancy
- enter_pulse  out  LANES  one-cycle pulse per completed entry
- exit_pulse  out  LANES  one-cycle pulse per completed exit
- full  out  1  count == CAPACITY
- empty  out  1  count == 0
- reject  out  1  one-cycle pulse; one or more entries were dropped at capacity

Behaviour:
- Reset (async, active-high): all lane FSMs go to IDLE; count=0; empty=1; full=0; all pulses and reject=0. A reset mid-sequence abandons that sequence with no event.
- Per-lane FSM, sampled {A,B} each posedge:
  - IDLE: 10->E1; 01->X1; 00 or 11->IDLE.
  - E1: 11->E2; 00->IDLE (abort); 10 stays.
  - E2: 01->E3; 10->E1 (back-out); 00->IDLE.
  - E3: 00->IDLE and entry event; 11->E2; 01 stays.
  - X1, X2, X3: mirror of E1, E2, E3 with A and B swapped; X3 with 00 gives an exit event.
  - Any other pattern goes to IDLE with no event.
- Event latency:
  - enter_pulse[i] / exit_pulse[i] is registered and high for exactly one cycle, on the edge where the FSM leaves E3/X3 on 00.
  - count, full, empty and reject update on that same edge.
- Arithmetic, per cycle:
  - E = popcount(entry events); X = popcount(exit events).
  - Exits are applied first: c1 = max(count - X, 0).
  - Entries are then applied: accepted = min(E, CAPACITY - c1); count_next = c1 + accepted.
  - reject = 1 if accepted < E.
  - Intermediates use CNT_W+4 bits; no wrap-around at either bound.
- enter_pulse reports lane-level detection, including rejected entries. Exit at 0 is ignored silently (no pulse suppression, count holds 0).
- full and empty are registered and derived from count_next.

Optional Feature:
- Macro OCC_PEAK_EN.
- Defined: adds output peak (CNT_W) and input peak_clr (1).
  - peak resets to 0 and updates to max(peak, count_next) each cycle.
  - peak_clr=1 loads count_next, taking priority over the max.
- Undefined: no peak ports or register; all other behaviour is identical.

Decomposition:
- Package parking_pkg:
  - lane_state_t enum {IDLE, E1, E2, E3, X1, X2, X3}
  - 2-bit sensor pattern constants P_CLEAR=00, P_A=10, P_B=01, P_BOTH=11
  - function sat_update(count, E, X, CAPACITY)
- Sub-module gate_lane_fsm, generated LANES times: inputs clk, reset, a, b; outputs enter_evt, exit_evt.
- Top level: popcount, saturating update, flags.

Test Plan:
- Reset, then lane0 drives 00,10,11,01,00 four times -> four enter_pulse[0] pulses; count=4; empty=0.
- From count=4, lane1 drives 00,01,11,10,00 three times -> count=1; then one more exit sequence -> count=0, empty=1; a further exit keeps count=0.
- Aborts: lane0 drives 10,00, then 10,11,10,00, then 10,11,01,11,01,00 -> only the last sequence counts; count=1 (from 0).
- CAPACITY=25 preloaded to 24: lanes 0 and 1 both complete entries on the same cycle -> count=25, full=1, reject=1 for one cycle, both enter_pulse bits high.
- count=10: lane0 entry and lane1 exit complete on the same cycle -> count=10, no reject; reset asserted mid-sequence (lane0 in E2) -> count=0, and completing the remaining 01,00 yields no event.
- OCC_PEAK_EN defined: enter 5, exit 3 -> peak=5, count=2; peak_clr pulse -> peak=2.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types, sensor pattern constants and the saturating occupancy update
// for the parking occupancy tracker.
package parking_pkg;

    // Wide enough for CNT_W (max 8 bits for CAPACITY<=255) plus 4 bits of headroom.
    localparam int unsigned SAT_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        E1,
        E2,
        E3,
        X1,
        X2,
        X3
    } lane_state_t;

    // Sensor patterns are {A,B}; 1 = beam blocked.
    localparam logic [1:0] P_CLEAR = 2'b00;
    localparam logic [1:0] P_A     = 2'b10;
    localparam logic [1:0] P_B     = 2'b01;
    localparam logic [1:0] P_BOTH  = 2'b11;

    typedef struct packed {
        logic             rej;
        logic [SAT_W-1:0] cnt;
    } sat_result_t;

    // Exits first (floored at zero), then entries limited by the remaining room.
    function automatic sat_result_t sat_update(
        input logic [SAT_W-1:0] count,
        input logic [SAT_W-1:0] e,
        input logic [SAT_W-1:0] x,
        input logic [SAT_W-1:0] cap
    );
        sat_result_t      res;
        logic [SAT_W-1:0] c1;
        logic [SAT_W-1:0] room;
        logic [SAT_W-1:0] acc;
        c1      = (x >= count) ? '0 : (count - x);
        room    = (cap > c1) ? (cap - c1) : '0;
        acc     = (e > room) ? room : e;
        res.cnt = c1 + acc;
        res.rej = (acc < e);
        return res;
    endfunction

endpackage

// File: rtl/parking_occupancy_tracker_lane.sv
// One gate lane: A/B sensor sequence FSM that flags a completed entry or exit
// combinationally on the cycle it leaves E3/X3 with both beams clear.
module gate_lane_fsm
    import parking_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic enter_evt,
    output logic exit_evt
);

    lane_state_t state_q, state_d;
    logic [1:0]  pat;

    assign pat = {a, b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = IDLE;
        enter_evt = 1'b0;
        exit_evt  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pat == P_A)      state_d = E1;
                else if (pat == P_B) state_d = X1;
            end
            E1: begin
                if (pat == P_BOTH)   state_d = E2;
                else if (pat == P_A) state_d = E1;
            end
            E2: begin
                if (pat == P_B)      state_d = E3;
                else if (pat == P_A) state_d = E1;
            end
            E3: begin
                if (pat == P_CLEAR)     enter_evt = 1'b1;
                else if (pat == P_BOTH) state_d   = E2;
                else if (pat == P_B)    state_d   = E3;
            end
            X1: begin
                if (pat == P_BOTH)   state_d = X2;
                else if (pat == P_B) state_d = X1;
            end
            X2: begin
                if (pat == P_A)      state_d = X3;
                else if (pat == P_B) state_d = X1;
            end
            X3: begin
                if (pat == P_CLEAR)     exit_evt = 1'b1;
                else if (pat == P_BOTH) state_d  = X2;
                else if (pat == P_A)    state_d  = X3;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/parking_occupancy_tracker.sv
// Multi-lane parking occupancy tracker: N gate lanes feed one saturating counter.
// Optional peak-occupancy register enabled by defining OCC_PEAK_EN.
module parking_occupancy_tracker
    import parking_pkg::*;
#(
    parameter int unsigned LANES    = 2,
    parameter int unsigned CAPACITY = 25,
    parameter int unsigned CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] sensor_a,
    input  logic [LANES-1:0] sensor_b,
    output logic [CNT_W-1:0] count,
    output logic [LANES-1:0] enter_pulse,
    output logic [LANES-1:0] exit_pulse,
    output logic             full,
    output logic             empty,
    output logic             reject
`ifdef OCC_PEAK_EN
    ,
    input  logic             peak_clr,
    output logic [CNT_W-1:0] peak
`endif
);

    logic [LANES-1:0] enter_evt;
    logic [LANES-1:0] exit_evt;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gate_lane_fsm u_lane (
            .clk       (clk),
            .reset     (reset),
            .a         (sensor_a[i]),
            .b         (sensor_b[i]),
            .enter_evt (enter_evt[i]),
            .exit_evt  (exit_evt[i])
        );
    end

    logic [SAT_W-1:0] n_enter;
    logic [SAT_W-1:0] n_exit;
    sat_result_t      upd;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             reject_q, reject_d;
    logic [LANES-1:0] enter_pulse_q;
    logic [LANES-1:0] exit_pulse_q;

    // Net all lanes' events in one update so simultaneous traffic is never lost.
    always_comb begin
        n_enter = '0;
        n_exit  = '0;
        for (int i = 0; i < LANES; i++) begin
            n_enter = n_enter + SAT_W'(enter_evt[i]);
            n_exit  = n_exit  + SAT_W'(exit_evt[i]);
        end
        upd      = sat_update(SAT_W'(count_q), n_enter, n_exit, SAT_W'(CAPACITY));
        count_d  = CNT_W'(upd.cnt);
        reject_d = upd.rej;
        full_d   = (count_d == CNT_W'(CAPACITY));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            reject_q      <= 1'b0;
            enter_pulse_q <= '0;
            exit_pulse_q  <= '0;
        end else begin
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            reject_q      <= reject_d;
            enter_pulse_q <= enter_evt;
            exit_pulse_q  <= exit_evt;
        end
    end

    assign count       = count_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign reject      = reject_q;
    assign enter_pulse = enter_pulse_q;
    assign exit_pulse  = exit_pulse_q;

`ifdef OCC_PEAK_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    // A clear reloads with the incoming count rather than zero.
    always_comb begin
        peak_d = peak_q;
        if (peak_clr)               peak_d = count_d;
        else if (count_d > peak_q)  peak_d = count_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) peak_q <= '0;
        else       peak_q <= peak_d;
    end

    assign peak = peak_q;
`endif

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Scoreboard bench for parking_occupancy_tracker (LANES=2, CAPACITY=25).
module tb_parking_occupancy_tracker;

    localparam int unsigned LANES    = 2;
    localparam int unsigned CAPACITY = 25;
    localparam int unsigned CNT_W    = $clog2(CAPACITY + 1);

    logic             clk;
    logic             reset;
    logic [LANES-1:0] sensor_a;
    logic [LANES-1:0] sensor_b;
    logic [CNT_W-1:0] count;
    logic [LANES-1:0] enter_pulse;
    logic [LANES-1:0] exit_pulse;
    logic             full;
    logic             empty;
    logic             reject;
`ifdef OCC_PEAK_EN
    logic             peak_clr;
    logic [CNT_W-1:0] peak;
`endif

    parking_occupancy_tracker #(
        .LANES    (LANES),
        .CAPACITY (CAPACITY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sensor_a    (sensor_a),
        .sensor_b    (sensor_b),
        .count       (count),
        .enter_pulse (enter_pulse),
        .exit_pulse  (exit_pulse),
        .full        (full),
        .empty       (empty),
        .reject      (reject)
`ifdef OCC_PEAK_EN
        ,
        .peak_clr    (peak_clr),
        .peak        (peak)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int en;
        int ex;
        int full;
        int empty;
        int rej;
        int pk;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: state codes 0=IDLE, 1..3=E1..E3, 4..6=X1..X3.
    int m_state[LANES];
    int m_count = 0;
    int m_peak  = 0;
    bit m_clr   = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Exit directions reuse the entry table with A and B swapped.
    function automatic void lane_step(input int st, input bit a, input bit b,
                                      output int nst, output bit done);
        int  p;
        bit  aa, bb;
        int  off;
        done = 1'b0;
        nst  = 0;
        if (st == 0) begin
            if (a && !b)      nst = 1;
            else if (!a && b) nst = 4;
        end else begin
            off = (st >= 4) ? 3 : 0;
            p   = st - off;
            aa  = (st >= 4) ? b : a;
            bb  = (st >= 4) ? a : b;
            case (p)
                1: if (aa && bb) nst = 2 + off; else if (aa && !bb) nst = 1 + off;
                2: if (!aa && bb) nst = 3 + off; else if (aa && !bb) nst = 1 + off;
                3: if (!aa && !bb) done = 1'b1;
                   else if (aa && bb) nst = 2 + off;
                   else if (!aa && bb) nst = 3 + off;
                default: nst = 0;
            endcase
        end
    endfunction

    task automatic drive(input logic [LANES-1:0] a_v, input logic [LANES-1:0] b_v);
        exp_t e;
        exp_t g;
        int   ne, nx, c1, room, acc, nst;
        bit   done;
        sensor_a = a_v;
        sensor_b = b_v;
        e.en = 0; e.ex = 0; ne = 0; nx = 0;
        for (int i = 0; i < LANES; i++) begin
            lane_step(m_state[i], a_v[i], b_v[i], nst, done);
            if (done && m_state[i] == 3) begin e.en |= (1 << i); ne++; end
            if (done && m_state[i] == 6) begin e.ex |= (1 << i); nx++; end
            m_state[i] = nst;
        end
        c1      = (m_count > nx) ? m_count - nx : 0;
        room    = CAPACITY - c1;
        acc     = (ne < room) ? ne : room;
        e.rej   = (acc < ne) ? 1 : 0;
        m_count = c1 + acc;
        if (m_clr || m_count > m_peak) m_peak = m_count;
        e.cnt   = m_count;
        e.full  = (m_count == CAPACITY) ? 1 : 0;
        e.empty = (m_count == 0) ? 1 : 0;
        e.pk    = m_peak;
        q.push_back(e);
        @(posedge clk);
        #1;
        g = q.pop_front();
        check_eq("count", int'(count), g.cnt);
        check_eq("enter_pulse", int'(enter_pulse), g.en);
        check_eq("exit_pulse", int'(exit_pulse), g.ex);
        check_eq("full", int'(full), g.full);
        check_eq("empty", int'(empty), g.empty);
        check_eq("reject", int'(reject), g.rej);
`ifdef OCC_PEAK_EN
        check_eq("peak", int'(peak), g.pk);
`endif
    endtask

    task automatic pat(input int lane, input logic [1:0] ab);
        logic [LANES-1:0] a_v;
        logic [LANES-1:0] b_v;
        a_v = '0;
        b_v = '0;
        a_v[lane] = ab[1];
        b_v[lane] = ab[0];
        drive(a_v, b_v);
    endtask

    task automatic enter_seq(input int lane);
        pat(lane, 2'b10); pat(lane, 2'b11); pat(lane, 2'b01); pat(lane, 2'b00);
    endtask

    task automatic exit_seq(input int lane);
        pat(lane, 2'b01); pat(lane, 2'b11); pat(lane, 2'b10); pat(lane, 2'b00);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        for (int i = 0; i < LANES; i++) m_state[i] = 0;
        m_count = 0;
        m_peak  = 0;
        #2;
        check_eq("rst_count", int'(count), 0);
        check_eq("rst_empty", int'(empty), 1);
        check_eq("rst_full", int'(full), 0);
        check_eq("rst_reject", int'(reject), 0);
        check_eq("rst_pulses", int'({enter_pulse, exit_pulse}), 0);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        sensor_a = '0;
        sensor_b = '0;
`ifdef OCC_PEAK_EN
        peak_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // Four entries on lane 0.
        pat(0, 2'b00);
        for (int k = 0; k < 4; k++) enter_seq(0);
        check_eq("after_4_enter", int'(count), 4);
        check_eq("not_empty", int'(empty), 0);

        // Exits on lane 1, including one at zero.
        for (int k = 0; k < 3; k++) exit_seq(1);
        check_eq("after_3_exit", int'(count), 1);
        exit_seq(1);
        check_eq("empty_again", int'(empty), 1);
        exit_seq(1);
        check_eq("exit_at_zero", int'(count), 0);

        // Aborted and backed-out entries; only the last completes.
        pat(0, 2'b10); pat(0, 2'b00);
        pat(0, 2'b10); pat(0, 2'b11); pat(0, 2'b10); pat(0, 2'b00);
        pat(0, 2'b10); pat(0, 2'b11); pat(0, 2'b01);
        pat(0, 2'b11); pat(0, 2'b01); pat(0, 2'b00);
        check_eq("after_aborts", int'(count), 1);

        // Fill to 24, then two simultaneous entries at capacity.
        for (int k = 0; k < 23; k++) enter_seq(k % 2);
        check_eq("preload_24", int'(count), 24);
        drive(2'b11, 2'b00);
        drive(2'b11, 2'b11);
        drive(2'b00, 2'b11);
        drive(2'b00, 2'b00);
        check_eq("cap_count", int'(count), 25);
        check_eq("cap_full", int'(full), 1);
        check_eq("cap_reject", int'(reject), 1);
        check_eq("cap_both_enter", int'(enter_pulse), 3);
        pat(0, 2'b00);
        check_eq("reject_one_cycle", int'(reject), 0);

        // Down to 10, then simultaneous entry (lane 0) and exit (lane 1).
        for (int k = 0; k < 15; k++) exit_seq(1);
        check_eq("down_to_10", int'(count), 10);
        drive(2'b01, 2'b10);
        drive(2'b11, 2'b11);
        drive(2'b10, 2'b01);
        drive(2'b00, 2'b00);
        check_eq("net_count", int'(count), 10);
        check_eq("net_no_reject", int'(reject), 0);

        // Reset with lane 0 parked in E2; the tail of the sequence must be ignored.
        pat(0, 2'b10); pat(0, 2'b11);
        apply_reset();
        pat(0, 2'b01); pat(0, 2'b00);
        check_eq("post_reset_count", int'(count), 0);
        check_eq("post_reset_no_enter", int'(enter_pulse), 0);

`ifdef OCC_PEAK_EN
        for (int k = 0; k < 5; k++) enter_seq(0);
        for (int k = 0; k < 3; k++) exit_seq(1);
        check_eq("peak_held", int'(peak), 5);
        check_eq("peak_count", int'(count), 2);
        peak_clr = 1'b1;
        m_clr    = 1'b1;
        pat(0, 2'b00);
        peak_clr = 1'b0;
        m_clr    = 1'b0;
        check_eq("peak_cleared", int'(peak), 2);
`endif

        check_eq("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
